asteroid_manager: RTL and testbench
===================================

ASTEROID_MANAGER -- requirements
Module: asteroid_manager

Interface
REQ-001 SHALL have parameter NUM_AST, default 8: number of asteroid unit slots managed.
REQ-002 SHALL have parameter WIDTH, default 640: screen width in pixels.
REQ-003 SHALL have parameter HEIGHT, default 480: screen height in pixels.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port game_continue, input, 1 bit: game running; the FSM advances only while high.
REQ-007 SHALL have port start_level, input, 1 bit: one-cycle pulse requesting a new wave.
REQ-008 SHALL have port level_count, input, 4 bits: number of large asteroids in the wave, 1..NUM_AST.
REQ-009 SHALL have port rand_val, input, 32 bits: free-running random source.
REQ-010 SHALL have port hit_valid, input, 1 bit: collision report is valid.
REQ-011 SHALL have port hit_idx, input, $clog2(NUM_AST) bits: slot that was hit.
REQ-012 SHALL have port hit_x, input, $clog2(WIDTH) bits: integer X of the hit slot.
REQ-013 SHALL have port hit_y, input, $clog2(HEIGHT) bits: integer Y of the hit slot.
REQ-014 SHALL have port hit_ready, output, 1 bit: hit accepted on a cycle where hit_valid and hit_ready are both high.
REQ-015 SHALL have port new_asteroid, output, NUM_AST bits: one-hot, one-cycle slot load pulse.
REQ-016 SHALL have port asteroid_hit, output, NUM_AST bits: one-hot, one-cycle slot kill pulse.
REQ-017 SHALL have port ast_type, output, NUM_AST x ast_t: registered type per slot.
REQ-018 SHALL have port x_init, output, $clog2(WIDTH) bits: broadcast start X, valid with new_asteroid.
REQ-019 SHALL have port y_init, output, $clog2(HEIGHT) bits: broadcast start Y, valid with new_asteroid.
REQ-020 SHALL have port phase_n, output, 10 bits: broadcast heading, valid with new_asteroid.
REQ-021 SHALL have port phase_inc_n, output, 4 bits: broadcast spin rate, valid with new_asteroid.
REQ-022 SHALL have port active, output, NUM_AST bits: slot occupied.
REQ-023 SHALL have port score_valid, output, 1 bit, plus score_type, output, ast_t: type of a destroyed asteroid.
REQ-024 SHALL have port field_clear, output, 1 bit: one-cycle pulse when the last asteroid dies.
REQ-025 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-026 SHALL implement the FSM states IDLE, SPAWN, KILL, SPLIT_A and SPLIT_B; all outputs are registered.
REQ-027 SHALL hold state, counters and outputs while game_continue is low; all pulses are forced to 0 during that time.
REQ-028 SHALL go from IDLE to SPAWN on start_level, loading spawn counter = level_count; start_level outside IDLE is ignored.
REQ-029 SHALL, in SPAWN, allocate one free slot per cycle (lowest free index), pulse its new_asteroid bit, set type AST_LARGE, and decrement the counter.
  - Broadcast values for a spawned asteroid: x_init = rand_val[25:16] reduced by WIDTH if >= WIDTH; y_init = 0; phase_n = rand_val[9:0]; phase_inc_n = rand_val[13:10] | 1.
REQ-030 SHALL return SPAWN to IDLE when the counter reaches 0 or no slot is free; remaining spawns are dropped.
REQ-031 SHALL drive hit_ready high only in IDLE with game_continue high and start_level low; start_level wins over hit_valid in the same cycle.
REQ-032 SHALL, on hit accept at cycle T with active[hit_idx]=1, latch idx/x/y/type and go to KILL.
  - At T+1: pulse asteroid_hit[idx], clear active[idx], pulse score_valid with score_type = latched type.
REQ-033 SHALL treat a hit on an inactive slot as accepted and discarded: no pulses, remain in IDLE.
REQ-034 SHALL leave KILL to IDLE for type AST_SMALL; for AST_LARGE or AST_MED it goes to SPLIT_A with child type LARGE->MED, MED->SMALL.
REQ-035 SHALL, in SPLIT_A (T+2) and SPLIT_B (T+3), each allocate the lowest free slot with new_asteroid, the child type, x_init=hit_x and y_init=hit_y.
  - phase_n = rand_val[9:0] in SPLIT_A; the same value + 512 (mod 1024) in SPLIT_B; phase_inc_n = rand_val[13:10] | 1.
  - If no slot is free, that child is dropped without a pulse.
  - SPLIT_B returns to IDLE.
REQ-036 SHALL allow the killed slot to be reused by SPLIT_A.
REQ-037 SHALL pulse field_clear for one cycle when active becomes all-zero in KILL with a SMALL type, at T+2.
REQ-038 SHALL keep x_init/y_init/phase_n/phase_inc_n stable at their last values when no new_asteroid pulse is active.

Reset
REQ-039 SHALL, while resetN is low, asynchronously set state=IDLE, new_asteroid=0, asteroid_hit=0, active=0, ast_type=all AST_SMALL, x_init=0, y_init=0, phase_n=0, phase_inc_n=0, score_valid=0, field_clear=0, busy=0, and the counters to 0.
REQ-040 SHALL abandon any in-progress spawn or split on reset; no pulse is emitted in the first cycle after release.

Verification
REQ-041 SHALL pass: start_level with level_count=3, rand_val[25:16]=700, WIDTH=640 -> new_asteroid=0x01,0x02,0x04 on 3 consecutive cycles, x_init=60, types LARGE, active=0x07.
REQ-042 SHALL pass: hit on slot 1 (LARGE) at x=100,y=200, rand[9:0]=600 -> asteroid_hit=0x02 at T+1; new_asteroid 0x02 (phase 600) at T+2 and 0x08 (phase 88) at T+3, both MED at (100,200).
REQ-043 SHALL pass: hit on the only active SMALL slot -> asteroid_hit at T+1, score_type SMALL, field_clear at T+2, active=0.
REQ-044 SHALL pass: all 8 slots active, hit on a MED -> killed slot reused by SPLIT_A, SPLIT_B child dropped, active stays 0xFF.
REQ-045 SHALL pass: game_continue low at T+2 of a split for 5 cycles -> no pulses; SPLIT_A pulse appears on the first cycle after game_continue returns high.
REQ-046 SHALL pass: resetN asserted in SPLIT_A -> all outputs 0 immediately, IDLE after release, hit_ready=1 with game_continue=1.

Source files
------------

// File: rtl/asteroid_manager.sv
// Asteroid slot manager: spawns waves, retires hit asteroids and splits them
// into two smaller children, broadcasting start parameters to the slot units.
module asteroid_manager #(
  parameter int unsigned NUM_AST = 8,
  parameter int unsigned WIDTH   = 640,
  parameter int unsigned HEIGHT  = 480
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       game_continue,
  input  logic                       start_level,
  input  logic [3:0]                 level_count,
  input  logic [31:0]                rand_val,
  input  logic                       hit_valid,
  input  logic [$clog2(NUM_AST)-1:0] hit_idx,
  input  logic [$clog2(WIDTH)-1:0]   hit_x,
  input  logic [$clog2(HEIGHT)-1:0]  hit_y,
  output logic                       hit_ready,
  output logic [NUM_AST-1:0]         new_asteroid,
  output logic [NUM_AST-1:0]         asteroid_hit,
  output logic [NUM_AST-1:0][1:0]    ast_type,
  output logic [$clog2(WIDTH)-1:0]   x_init,
  output logic [$clog2(HEIGHT)-1:0]  y_init,
  output logic [9:0]                 phase_n,
  output logic [3:0]                 phase_inc_n,
  output logic [NUM_AST-1:0]         active,
  output logic                       score_valid,
  output logic [1:0]                 score_type,
  output logic                       field_clear,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NUM_AST);
  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  // Asteroid size encoding; SMALL is zero so reset leaves every slot SMALL.
  localparam logic [1:0] AST_SMALL = 2'd0;
  localparam logic [1:0] AST_MED   = 2'd1;
  localparam logic [1:0] AST_LARGE = 2'd2;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSpawn  = 3'd1;
  localparam logic [2:0] StKill   = 3'd2;
  localparam logic [2:0] StSplitA = 3'd3;
  localparam logic [2:0] StSplitB = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [3:0]               spawn_cnt_q, spawn_cnt_d;
  logic [NUM_AST-1:0]       active_q, active_d;
  logic [NUM_AST-1:0][1:0]  ast_type_q, ast_type_d;
  logic [NUM_AST-1:0]       new_ast_q, new_ast_d;
  logic [NUM_AST-1:0]       ast_hit_q, ast_hit_d;
  logic [XW-1:0]            x_init_q, x_init_d;
  logic [YW-1:0]            y_init_q, y_init_d;
  logic [9:0]               phase_q, phase_d;
  logic [3:0]               phase_inc_q, phase_inc_d;
  logic                     score_valid_q, score_valid_d;
  logic [1:0]               score_type_q, score_type_d;
  logic                     field_clear_q, field_clear_d;
  logic                     busy_q, busy_d;
  logic [XW-1:0]            hit_x_q, hit_x_d;
  logic [YW-1:0]            hit_y_q, hit_y_d;
  logic [1:0]               hit_type_q, hit_type_d;
  logic [9:0]               split_phase_q, split_phase_d;

  logic                     free_found;
  logic [IW-1:0]            free_idx;
  logic [NUM_AST-1:0]       free_oh;
  logic [9:0]               rand_x;
  logic [9:0]               spawn_x;
  logic [9:0]               rand_phase;
  logic [3:0]               rand_inc;

  logic                     alloc_req;
  logic [1:0]               alloc_type;
  logic [XW-1:0]            alloc_x;
  logic [YW-1:0]            alloc_y;
  logic [9:0]               alloc_phase;

  logic                     unused_rand;
  assign unused_rand = ^{rand_val[31:26], rand_val[15:14]};

  assign rand_x     = rand_val[25:16];
  assign spawn_x    = (32'(rand_x) >= WIDTH) ? rand_x - 10'(WIDTH) : rand_x;
  assign rand_phase = rand_val[9:0];
  // Odd spin rate so an asteroid never sits still.
  assign rand_inc   = rand_val[13:10] | 4'd1;

  // Handshake ready is a live qualifier of the request inputs, so start_level
  // blocks a same-cycle hit.
  assign hit_ready = (state_q == StIdle) && game_continue && !start_level;

  // Lowest-index free slot.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    free_oh    = '0;
    for (int i = NUM_AST - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    if (free_found) begin
      free_oh[free_idx] = 1'b1;
    end
  end

  // FSM next state; each transition loads the outputs belonging to the state entered.
  always_comb begin
    state_d       = state_q;
    spawn_cnt_d   = spawn_cnt_q;
    active_d      = active_q;
    ast_type_d    = ast_type_q;
    x_init_d      = x_init_q;
    y_init_d      = y_init_q;
    phase_d       = phase_q;
    phase_inc_d   = phase_inc_q;
    score_type_d  = score_type_q;
    hit_x_d       = hit_x_q;
    hit_y_d       = hit_y_q;
    hit_type_d    = hit_type_q;
    split_phase_d = split_phase_q;
    new_ast_d     = '0;
    ast_hit_d     = '0;
    score_valid_d = 1'b0;
    field_clear_d = 1'b0;
    alloc_req     = 1'b0;
    alloc_type    = AST_LARGE;
    alloc_x       = XW'(spawn_x);
    alloc_y       = '0;
    alloc_phase   = rand_phase;

    if (game_continue) begin
      case (state_q)
        StIdle: begin
          if (start_level) begin
            if (level_count != 4'd0 && free_found) begin
              alloc_req   = 1'b1;
              spawn_cnt_d = level_count - 4'd1;
              state_d     = StSpawn;
            end
          end else if (hit_valid && active_q[hit_idx]) begin
            ast_hit_d[hit_idx] = 1'b1;
            active_d[hit_idx]  = 1'b0;
            score_valid_d      = 1'b1;
            score_type_d       = ast_type_q[hit_idx];
            hit_type_d         = ast_type_q[hit_idx];
            hit_x_d            = hit_x;
            hit_y_d            = hit_y;
            state_d            = StKill;
          end
          // A hit on an empty slot is consumed without effect.
        end
        StSpawn: begin
          if (spawn_cnt_q != 4'd0 && free_found) begin
            alloc_req   = 1'b1;
            spawn_cnt_d = spawn_cnt_q - 4'd1;
          end else begin
            spawn_cnt_d = 4'd0;
            state_d     = StIdle;
          end
        end
        StKill: begin
          if (hit_type_q == AST_SMALL) begin
            field_clear_d = (active_q == '0);
            state_d       = StIdle;
          end else begin
            // The killed slot is already free here, so child A may reuse it.
            alloc_req     = 1'b1;
            alloc_type    = (hit_type_q == AST_LARGE) ? AST_MED : AST_SMALL;
            alloc_x       = hit_x_q;
            alloc_y       = hit_y_q;
            split_phase_d = rand_phase;
            state_d       = StSplitA;
          end
        end
        StSplitA: begin
          // Second child flies off in the opposite direction.
          alloc_req   = 1'b1;
          alloc_type  = (hit_type_q == AST_LARGE) ? AST_MED : AST_SMALL;
          alloc_x     = hit_x_q;
          alloc_y     = hit_y_q;
          alloc_phase = split_phase_q + 10'd512;
          state_d     = StSplitB;
        end
        StSplitB: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      if (alloc_req && free_found) begin
        new_ast_d            = free_oh;
        active_d             = active_d | free_oh;
        ast_type_d[free_idx] = alloc_type;
        x_init_d             = alloc_x;
        y_init_d             = alloc_y;
        phase_d              = alloc_phase;
        phase_inc_d          = rand_inc;
      end
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      spawn_cnt_q   <= '0;
      active_q      <= '0;
      ast_type_q    <= '0;
      new_ast_q     <= '0;
      ast_hit_q     <= '0;
      x_init_q      <= '0;
      y_init_q      <= '0;
      phase_q       <= '0;
      phase_inc_q   <= '0;
      score_valid_q <= 1'b0;
      score_type_q  <= AST_SMALL;
      field_clear_q <= 1'b0;
      busy_q        <= 1'b0;
      hit_x_q       <= '0;
      hit_y_q       <= '0;
      hit_type_q    <= AST_SMALL;
      split_phase_q <= '0;
    end else begin
      state_q       <= state_d;
      spawn_cnt_q   <= spawn_cnt_d;
      active_q      <= active_d;
      ast_type_q    <= ast_type_d;
      new_ast_q     <= new_ast_d;
      ast_hit_q     <= ast_hit_d;
      x_init_q      <= x_init_d;
      y_init_q      <= y_init_d;
      phase_q       <= phase_d;
      phase_inc_q   <= phase_inc_d;
      score_valid_q <= score_valid_d;
      score_type_q  <= score_type_d;
      field_clear_q <= field_clear_d;
      busy_q        <= busy_d;
      hit_x_q       <= hit_x_d;
      hit_y_q       <= hit_y_d;
      hit_type_q    <= hit_type_d;
      split_phase_q <= split_phase_d;
    end
  end

  assign new_asteroid = new_ast_q;
  assign asteroid_hit = ast_hit_q;
  assign ast_type     = ast_type_q;
  assign x_init       = x_init_q;
  assign y_init       = y_init_q;
  assign phase_n      = phase_q;
  assign phase_inc_n  = phase_inc_q;
  assign active       = active_q;
  assign score_valid  = score_valid_q;
  assign score_type   = score_type_q;
  assign field_clear  = field_clear_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_asteroid_manager.sv
// Scoreboard bench for asteroid_manager: stimulus tasks push expected pulses,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_asteroid_manager;

  localparam int W = 640;
  localparam logic [1:0] SMALL = 2'd0;
  localparam logic [1:0] MED   = 2'd1;
  localparam logic [1:0] LARGE = 2'd2;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        game_continue = 1'b0;
  logic        start_level = 1'b0;
  logic [3:0]  level_count = '0;
  logic [31:0] rand_val = '0;
  logic        hit_valid = 1'b0;
  logic [2:0]  hit_idx = '0;
  logic [9:0]  hit_x = '0;
  logic [8:0]  hit_y = '0;
  logic        hit_ready;
  logic [7:0]  new_asteroid;
  logic [7:0]  asteroid_hit;
  logic [7:0][1:0] ast_type;
  logic [9:0]  x_init;
  logic [8:0]  y_init;
  logic [9:0]  phase_n;
  logic [3:0]  phase_inc_n;
  logic [7:0]  active;
  logic        score_valid;
  logic [1:0]  score_type;
  logic        field_clear;
  logic        busy;

  asteroid_manager #(.NUM_AST(8), .WIDTH(640), .HEIGHT(480)) dut (
    .clk(clk), .resetN(resetN), .game_continue(game_continue),
    .start_level(start_level), .level_count(level_count), .rand_val(rand_val),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_x(hit_x), .hit_y(hit_y),
    .hit_ready(hit_ready), .new_asteroid(new_asteroid), .asteroid_hit(asteroid_hit),
    .ast_type(ast_type), .x_init(x_init), .y_init(y_init), .phase_n(phase_n),
    .phase_inc_n(phase_inc_n), .active(active), .score_valid(score_valid),
    .score_type(score_type), .field_clear(field_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] oh;
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] ph;
    logic [3:0] inc;
    logic [1:0] typ;
  } spawn_t;

  typedef struct {
    int         cyc;
    logic [7:0] oh;
    logic [1:0] typ;
  } kill_t;

  spawn_t sq[$];
  kill_t  kq[$];
  int     fq[$];
  spawn_t se;
  kill_t  ke;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of slot occupancy.
  logic [7:0] m_act = '0;
  logic [1:0] m_typ [8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] mk_rand(input int x10, input int inc4, input int ph10);
    return 32'((x10 << 16) | (inc4 << 10) | ph10);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_spawn(input int c, input int f, input logic [9:0] x, input logic [8:0] y,
                            input logic [9:0] ph, input logic [31:0] rnd, input logic [1:0] t);
    spawn_t e;
    e.cyc = c; e.idx = f; e.oh = 8'(1 << f); e.x = x; e.y = y; e.ph = ph;
    e.inc = rnd[13:10] | 4'd1; e.typ = t;
    sq.push_back(e);
    m_act[f] = 1'b1;
    m_typ[f] = t;
  endtask

  task automatic do_spawn(input int cnt, input logic [31:0] rnd);
    int n0, xv, f;
    n0 = cyc;
    xv = int'(rnd[25:16]);
    if (xv >= W) xv -= W;
    for (int k = 0; k < cnt; k++) begin
      f = lowest_free();
      if (f < 0) break;
      push_spawn(n0 + 1 + k, f, 10'(xv), 9'd0, rnd[9:0], rnd, LARGE);
    end
    rand_val = rnd; level_count = 4'(cnt); start_level = 1'b1;
    step(1);
    start_level = 1'b0;
    step(cnt + 3);
  endtask

  task automatic do_hit(input int idx, input int x, input int y, input logic [31:0] rnd,
                        input int hold);
    int n0, f;
    logic [1:0] t, ct;
    kill_t k;
    n0 = cyc;
    check_eq("hit_ready idle", hit_ready, 1'b1);
    if (m_act[idx]) begin
      t = m_typ[idx];
      k.cyc = n0 + 1; k.oh = 8'(1 << idx); k.typ = t;
      kq.push_back(k);
      m_act[idx] = 1'b0;
      if (t == SMALL) begin
        if (m_act == 8'h00) fq.push_back(n0 + 2);
      end else begin
        ct = (t == LARGE) ? MED : SMALL;
        for (int c = 0; c < 2; c++) begin
          f = lowest_free();
          if (f >= 0) push_spawn(n0 + 2 + hold + c, f, 10'(x), 9'(y),
                                 rnd[9:0] + (c == 1 ? 10'd512 : 10'd0), rnd, ct);
        end
      end
    end
    rand_val = rnd; hit_idx = 3'(idx); hit_x = 10'(x); hit_y = 9'(y); hit_valid = 1'b1;
    step(1);
    hit_valid = 1'b0;
    if (hold > 0) begin
      game_continue = 1'b0;
      step(2);
      check_eq("busy held", busy, 1'b1);
      check_eq("no pulse while held", new_asteroid, 8'h00);
      step(hold - 2);
      game_continue = 1'b1;
    end
    step(5);
  endtask

  // Monitor: every pulse must match the head of its queue in cycle and content.
  always @(negedge clk) begin
    if (resetN) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        check_eq("new_asteroid missing cyc", 64'(cyc), 64'(sq[0].cyc));
        void'(sq.pop_front());
      end
      while (kq.size() > 0 && kq[0].cyc < cyc) begin
        check_eq("asteroid_hit missing cyc", 64'(cyc), 64'(kq[0].cyc));
        void'(kq.pop_front());
      end
      while (fq.size() > 0 && fq[0] < cyc) begin
        check_eq("field_clear missing cyc", 64'(cyc), 64'(fq[0]));
        void'(fq.pop_front());
      end
      if (new_asteroid != 8'h00) begin
        if (sq.size() == 0 || sq[0].cyc != cyc) begin
          check_eq("unexpected new_asteroid", new_asteroid, 8'h00);
        end else begin
          se = sq.pop_front();
          check_eq("new_asteroid", new_asteroid, se.oh);
          check_eq("x_init", x_init, se.x);
          check_eq("y_init", y_init, se.y);
          check_eq("phase_n", phase_n, se.ph);
          check_eq("phase_inc_n", phase_inc_n, se.inc);
          check_eq("ast_type new", ast_type[se.idx], se.typ);
        end
      end
      if (asteroid_hit != 8'h00 || score_valid) begin
        if (kq.size() == 0 || kq[0].cyc != cyc) begin
          check_eq("unexpected asteroid_hit", {score_valid, asteroid_hit}, 9'h000);
        end else begin
          ke = kq.pop_front();
          check_eq("asteroid_hit", asteroid_hit, ke.oh);
          check_eq("score_valid", score_valid, 1'b1);
          check_eq("score_type", score_type, ke.typ);
        end
      end
      if (field_clear) begin
        if (fq.size() == 0 || fq[0] != cyc) check_eq("unexpected field_clear", field_clear, 1'b0);
        else void'(fq.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_typ[i] = SMALL;
    #2 resetN = 1'b0;
    #2;
    check_eq("rst new_asteroid", new_asteroid, 8'h00);
    check_eq("rst active", active, 8'h00);
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst ast_type", ast_type, 16'h0000);
    check_eq("rst x_init", x_init, 10'd0);
    check_eq("rst phase_n", phase_n, 10'd0);
    check_eq("rst hit_ready gc0", hit_ready, 1'b0);
    step(2);
    resetN = 1'b1;
    step(1);
    game_continue = 1'b1;
    #1;
    check_eq("hit_ready after gc", hit_ready, 1'b1);
    step(1);

    // Wave of three; x wraps 700 -> 60.
    do_spawn(3, mk_rand(700, 4, 5));
    check_eq("wave active", active, 8'h07);
    for (int i = 0; i < 3; i++) check_eq("wave type LARGE", ast_type[i], LARGE);
    check_eq("x_init stable", x_init, 10'd60);
    check_eq("busy after wave", busy, 1'b0);

    // Split a LARGE: children at phase 600 and 88.
    do_hit(1, 100, 200, mk_rand(0, 2, 600), 0);
    check_eq("split active", active, 8'h0F);

    // Hit on an empty slot is swallowed.
    do_hit(6, 5, 5, mk_rand(0, 0, 0), 0);
    check_eq("empty hit active", active, 8'h0F);
    check_eq("empty hit busy", busy, 1'b0);

    // start_level beats a same-cycle hit.
    begin
      int n0, f;
      n0 = cyc;
      f = lowest_free();
      push_spawn(n0 + 1, f, 10'd300, 9'd0, 10'd100, mk_rand(300, 7, 100), LARGE);
      rand_val = mk_rand(300, 7, 100); level_count = 4'd1; start_level = 1'b1;
      hit_idx = 3'd0; hit_valid = 1'b1;
      #1;
      check_eq("hit_ready with start", hit_ready, 1'b0);
      step(1);
      start_level = 1'b0; hit_valid = 1'b0;
      step(4);
      check_eq("start wins active", active, 8'h1F);
    end

    // Request more than fits, then a wave into a full field.
    do_spawn(5, mk_rand(1023, 0, 1023));
    check_eq("full active", active, 8'hFF);
    do_spawn(2, mk_rand(1, 1, 1));
    check_eq("full no spawn", active, 8'hFF);
    check_eq("full busy", busy, 1'b0);

    // Full field, MED hit: slot reused, second child dropped.
    do_hit(1, 50, 60, mk_rand(10, 8, 20), 0);
    check_eq("reuse active", active, 8'hFF);
    check_eq("reuse type", ast_type[1], SMALL);

    // game_continue drops right after the kill for five cycles.
    do_hit(0, 33, 44, mk_rand(0, 3, 7), 5);
    check_eq("hold active", active, 8'hFF);

    // Reset while in SPLIT_A.
    begin
      int n0;
      kill_t k;
      n0 = cyc;
      check_eq("hit_ready pre-reset", hit_ready, 1'b1);
      k.cyc = n0 + 1; k.oh = 8'h04; k.typ = LARGE;
      kq.push_back(k);
      rand_val = mk_rand(0, 1, 1); hit_idx = 3'd2; hit_x = 10'd9; hit_y = 9'd9;
      hit_valid = 1'b1;
      step(1);
      hit_valid = 1'b0;
      step(1);
      resetN = 1'b0;
      #1;
      check_eq("async rst new_asteroid", new_asteroid, 8'h00);
      check_eq("async rst active", active, 8'h00);
      check_eq("async rst busy", busy, 1'b0);
      check_eq("async rst ast_type", ast_type, 16'h0000);
      check_eq("async rst x_init", x_init, 10'd0);
      check_eq("async rst phase_inc", phase_inc_n, 4'd0);
      m_act = '0;
      for (int i = 0; i < 8; i++) m_typ[i] = SMALL;
      step(2);
      resetN = 1'b1;
      #1;
      check_eq("post-reset hit_ready", hit_ready, 1'b1);
      check_eq("post-reset busy", busy, 1'b0);
      step(3);
    end

    // Whittle one LARGE down to nothing; last SMALL clears the field.
    do_spawn(1, mk_rand(123, 5, 321));
    do_hit(0, 10, 20, mk_rand(0, 1, 100), 0);
    do_hit(0, 30, 40, mk_rand(0, 2, 200), 0);
    do_hit(1, 50, 60, mk_rand(0, 3, 300), 0);
    check_eq("smalls active", active, 8'h0F);
    do_hit(0, 1, 1, mk_rand(0, 0, 0), 0);
    do_hit(1, 1, 1, mk_rand(0, 0, 0), 0);
    do_hit(2, 1, 1, mk_rand(0, 0, 0), 0);
    do_hit(3, 1, 1, mk_rand(0, 0, 0), 0);
    check_eq("cleared active", active, 8'h00);

    step(3);
    check_eq("spawn queue drained", 64'(sq.size()), 64'd0);
    check_eq("kill queue drained", 64'(kq.size()), 64'd0);
    check_eq("clear queue drained", 64'(fq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
